program_loader: RTL and testbench



---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 193 +++++++++++++++++++
 tb/tb_program_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
// The master side feeds bytes and observes writes; the slave side is the loader.
interface program_loader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into RAM as 10-bit words, holding the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    program_loader_if.slave   bus,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] load_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] load_count_q, load_count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        lo_q, lo_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              in_ready;
    logic              accept;
    logic              last_word;
    state_e            finish_state;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    function automatic logic hdr_hi_ok(input logic [7:0] b);
        return b[7:6] == 2'b00;
    endfunction

    function automatic logic data_hi_ok(input logic [7:0] b);
        return b[7:2] == 6'b0;
    endfunction

    function automatic logic [DATA_W-1:0] assemble_word(input logic [7:0] hi, input logic [7:0] lo);
        return DATA_W'({hi[1:0], lo});
    endfunction

    assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept    = bus.in_valid && in_ready;
    assign last_word = (load_count_q + ADDR_W'(1)) == count_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign finish_state = S_CHK;
`else
    assign finish_state = S_DONE;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        load_count_d = load_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        lo_d         = lo_q;
        mem_we_d     = 1'b0;
        done_d       = done_q;
        error_d      = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk_d        = chk_q;
`endif

        case (state_q)
            S_HDR_LO: begin
                if (accept) begin
                    lo_d    = bus.in_data;
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    if (!hdr_hi_ok(bus.in_data)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        count_d = ADDR_W'({bus.in_data[5:0], lo_q});
                        state_d = ({bus.in_data[5:0], lo_q} == 14'd0) ? finish_state : S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    lo_d    = bus.in_data;
                    state_d = S_DATA_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.in_data;
`endif
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    if (!data_hi_ok(bus.in_data)) begin
                        // Bad word is dropped; earlier words stay in RAM.
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        mem_we_d     = 1'b1;
                        mem_wdata_d  = assemble_word(bus.in_data, lo_q);
                        mem_addr_d   = BASE + load_count_q;
                        load_count_d = load_count_q + ADDR_W'(1);
                        state_d      = last_word ? finish_state : S_DATA_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        chk_d        = chk_q ^ bus.in_data;
`endif
                    end
                end
            end
            S_CHK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (accept) begin
                    if (bus.in_data == chk_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
`endif
            end
            // Entering DONE straight from a write raises done one edge later, after the write cycle.
            S_DONE: done_d = 1'b1;
            S_ERR:  ;
            default: state_d = S_ERR;
        endcase

        cpu_rst_d = ~done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HDR_LO;
            load_count_q <= '0;
            mem_addr_q   <= BASE;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_rst_q    <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_rst_q    <= cpu_rst_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    // Byte and count holding registers are always written before being read.
    always_ff @(posedge clk) begin
        lo_q    <= lo_d;
        count_q <= count_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
    assign error         = error_q;
    assign load_count    = load_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (BASE_ADDR 0 and 16383) share one byte stream.
// Honours PROGRAM_LOADER_CHECKSUM_EN by appending the checksum byte to each stream.
module tb_program_loader;

    typedef struct packed {
        logic [13:0] addr;
        logic [9:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   gap = 0;
    wr_t  q_a[$];
    wr_t  q_b[$];

    logic        cpu_rst_a, done_a, error_a;
    logic        cpu_rst_b, done_b, error_b;
    logic [13:0] load_count_a, load_count_b;

    program_loader_if #(.ADDR_W(14), .DATA_W(10)) tif_a ();
    program_loader_if #(.ADDR_W(14), .DATA_W(10)) tif_b ();

    assign tif_b.in_data  = tif_a.in_data;
    assign tif_b.in_valid = tif_a.in_valid;

    program_loader #(.ADDR_W(14), .DATA_W(10), .BASE_ADDR(0)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .bus        (tif_a.slave),
        .cpu_rst    (cpu_rst_a),
        .done       (done_a),
        .error      (error_a),
        .load_count (load_count_a)
    );

    program_loader #(.ADDR_W(14), .DATA_W(10), .BASE_ADDR(16383)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .bus        (tif_b.slave),
        .cpu_rst    (cpu_rst_b),
        .done       (done_b),
        .error      (error_b),
        .load_count (load_count_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Write monitors: every mem_we cycle must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (tif_a.mem_we) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write_a addr=0x%0h data=0x%0h expected=none", tif_a.mem_addr, tif_a.mem_wdata);
            end else begin
                e = q_a.pop_front();
                chk("write_a_addr", 32'(tif_a.mem_addr), 32'(e.addr));
                chk("write_a_data", 32'(tif_a.mem_wdata), 32'(e.data));
            end
        end
        if (tif_b.mem_we) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write_b addr=0x%0h data=0x%0h expected=none", tif_b.mem_addr, tif_b.mem_wdata);
            end else begin
                e = q_b.pop_front();
                chk("write_b_addr", 32'(tif_b.mem_addr), 32'(e.addr));
                chk("write_b_data", 32'(tif_b.mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic exp_write(input int idx, input logic [9:0] d);
        q_a.push_back('{addr: 14'(idx), data: d});
        q_b.push_back('{addr: 14'(16383 + idx), data: d});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tif_a.in_valid = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        tif_a.in_data  = b;
        tif_a.in_valid = 1'b1;
        while (!tif_a.in_ready && n < 20) begin
            cycles(1);
            n++;
        end
        if (!tif_a.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=0 expected=1 byte=0x%0h", b);
            tif_a.in_valid = 1'b0;
        end else begin
            cycles(1);
            tif_a.in_valid = 1'b0;
            if (gap > 0) cycles(gap);
        end
    endtask

    task automatic send_chk(input logic [7:0] b);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        b = b;
`endif
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                                input logic [13:0] exp_cnt);
        chk({tag, "_done_a"},     32'(done_a),       32'(exp_done));
        chk({tag, "_error_a"},    32'(error_a),      32'(exp_err));
        chk({tag, "_cpu_rst_a"},  32'(cpu_rst_a),    32'(!exp_done));
        chk({tag, "_count_a"},    32'(load_count_a), 32'(exp_cnt));
        chk({tag, "_in_ready_a"}, 32'(tif_a.in_ready), 32'(!(exp_done || exp_err)));
        chk({tag, "_done_b"},     32'(done_b),       32'(exp_done));
        chk({tag, "_error_b"},    32'(error_b),      32'(exp_err));
        chk({tag, "_count_b"},    32'(load_count_b), 32'(exp_cnt));
        chk({tag, "_sb_empty_a"}, 32'(q_a.size()),   32'd0);
        chk({tag, "_sb_empty_b"}, 32'(q_b.size()),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        tif_a.in_data  = 8'h00;
        tif_a.in_valid = 1'b0;
        do_reset();

        chk("rst_in_ready",   32'(tif_a.in_ready),  32'd1);
        chk("rst_mem_we",     32'(tif_a.mem_we),    32'd0);
        chk("rst_mem_addr_a", 32'(tif_a.mem_addr),  32'd0);
        chk("rst_mem_addr_b", 32'(tif_b.mem_addr),  32'd16383);
        chk("rst_mem_wdata",  32'(tif_a.mem_wdata), 32'd0);
        chk("rst_cpu_rst",    32'(cpu_rst_a),       32'd1);
        chk("rst_done",       32'(done_a),          32'd0);
        chk("rst_error",      32'(error_a),         32'd0);
        chk("rst_count",      32'(load_count_a),    32'd0);

        // Two-word image, base case and address wrap on instance B.
        send_byte(8'h02); send_byte(8'h00);
        exp_write(0, 10'h3FF);
        send_byte(8'hFF); send_byte(8'h03);
        exp_write(1, 10'h001);
        send_byte(8'h01); send_byte(8'h00);
        send_chk(8'hFD);
        cycles(3);
        check_status("t1", 1'b1, 1'b0, 14'd2);
        tif_a.in_data  = 8'h55;
        tif_a.in_valid = 1'b1;
        cycles(3);
        tif_a.in_valid = 1'b0;
        check_status("t1_ignore", 1'b1, 1'b0, 14'd2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Wrong checksum: words stay written, loader errors.
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        exp_write(0, 10'h3FF);
        send_byte(8'hFF); send_byte(8'h03);
        exp_write(1, 10'h001);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hFE);
        cycles(3);
        check_status("t2", 1'b0, 1'b1, 14'd2);
`endif

        // Reserved bits in a data HI byte.
        do_reset();
        send_byte(8'h03); send_byte(8'h00);
        exp_write(0, 10'h110);
        send_byte(8'h10); send_byte(8'h01);
        send_byte(8'h22); send_byte(8'h07);
        cycles(3);
        check_status("t3", 1'b0, 1'b1, 14'd1);

        // Empty image.
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        send_chk(8'h00);
        cycles(3);
        check_status("t4", 1'b1, 1'b0, 14'd0);

        // Reserved bits in header HI byte.
        do_reset();
        send_byte(8'h01); send_byte(8'h40);
        cycles(3);
        check_status("t5", 1'b0, 1'b1, 14'd0);

        // Reset lands on the edge that would accept the HI byte: no write, clean restart.
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h12);
        tif_a.in_data  = 8'h01;
        tif_a.in_valid = 1'b1;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        tif_a.in_valid = 1'b0;
        chk("t6_rst_count",    32'(load_count_a),   32'd0);
        chk("t6_rst_in_ready", 32'(tif_a.in_ready), 32'd1);
        chk("t6_rst_mem_we",   32'(tif_a.mem_we),   32'd0);
        send_byte(8'h01); send_byte(8'h00);
        exp_write(0, 10'h0AA);
        send_byte(8'hAA); send_byte(8'h00);
        send_chk(8'hAA);
        cycles(3);
        check_status("t6", 1'b1, 1'b0, 14'd1);

        // Three words with idle gaps between bytes.
        do_reset();
        gap = 2;
        send_byte(8'h03); send_byte(8'h00);
        exp_write(0, 10'h255);
        send_byte(8'h55); send_byte(8'h02);
        exp_write(1, 10'h1AA);
        send_byte(8'hAA); send_byte(8'h01);
        exp_write(2, 10'h000);
        send_byte(8'h00); send_byte(8'h00);
        send_chk(8'hFC);
        gap = 0;
        cycles(3);
        check_status("t7", 1'b1, 1'b0, 14'd3);

        cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
